hazard_ctrl: RTL and testbench

- Pipeline control unit that drives the PC register and the inter-stage registers of the five-stage pipeline.
- Produces the next PC value plus the stall and flush strobes consumed by the PC register, IF/ID, ID/EX and EX/MEM.
- Resolves load-use hazards, EX-stage branch redirects, MEM-stage traps and a fixed-latency multi-cycle EX operation (mul/div) through an internal FSM.

---
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control for the five-stage core.
// Chooses the next PC and drives the stall/flush strobes for the PC register,
// IF/ID, ID/EX and EX/MEM. Traps beat a running multi-cycle op, which beats
// branches, which beat load-use stalls.
module hazard_ctrl #(
    parameter int                     PC_WIDTH    = 64,
    parameter int                     REG_ADDR_W  = 5,
    parameter int                     MC_LATENCY  = 4,
    parameter logic [PC_WIDTH-1:0]    TRAP_VECTOR = PC_WIDTH'(64'h100)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   pc_cur,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_mc_start,
    input  logic                  br_taken_ex,
    input  logic [PC_WIDTH-1:0]   br_target_ex,
    input  logic                  trap_req_mem,
    output logic [PC_WIDTH-1:0]   pc_next,
    output logic                  pc_stall,
    output logic                  pc_flush,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mc_busy
);

    localparam int                CNT_W    = $clog2(MC_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MC_LATENCY - 2);
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use;

    // Load-use: the load in EX writes a nonzero register the ID instruction reads.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // State and countdown registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and strobe decode in priority order; reset silences every strobe.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_next      = pc_cur + PC_STEP;
        pc_stall     = 1'b0;
        pc_flush     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mc_busy      = 1'b0;

        if (rst) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else if (trap_req_mem) begin
            pc_next      = TRAP_VECTOR;
            pc_flush     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mc_busy      = (state == MC_WAIT);
            state_nxt    = RUN;
            cnt_nxt      = '0;
        end else if (state == MC_WAIT) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            mc_busy      = 1'b1;
            if (cnt == '0) begin
                state_nxt = RUN;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end else begin
            if (ex_mc_start && !br_taken_ex) begin
                state_nxt = MC_WAIT;
                cnt_nxt   = CNT_LOAD;
            end
            if (br_taken_ex) begin
                pc_next     = br_target_ex;
                pc_flush    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use && !ex_mc_start) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven check of the combinational priorities plus
// hand-written sequences for the multi-cycle, trap-abort and reset cases.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_cur;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_mc_start;
    logic        br_taken_ex, trap_req_mem;
    logic [63:0] br_target_ex;
    logic [63:0] pc_next;
    logic        pc_stall, pc_flush, if_id_stall, if_id_flush;
    logic        id_ex_stall, id_ex_flush, ex_mem_flush, mc_busy;

    int total = 0;
    int bad   = 0;

    // Strobe vector order: pc_stall pc_flush if_id_stall if_id_flush
    //                      id_ex_stall id_ex_flush ex_mem_flush mc_busy
    localparam logic [7:0] S_NONE = 8'b0000_0000;
    localparam logic [7:0] S_LU   = 8'b1010_0100;
    localparam logic [7:0] S_BR   = 8'b0101_0100;
    localparam logic [7:0] S_TRAP = 8'b0101_0110;
    localparam logic [7:0] S_BUSY = 8'b1010_1011;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mc_start;
        logic        br;
        logic [63:0] tgt;
        logic        trap;
        logic [63:0] exp_pc;
        logic [7:0]  exp_str;
    } vec_t;

    vec_t vecs[12];

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pc_cur       (pc_cur),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_mc_start  (ex_mc_start),
        .br_taken_ex  (br_taken_ex),
        .br_target_ex (br_target_ex),
        .trap_req_mem (trap_req_mem),
        .pc_next      (pc_next),
        .pc_stall     (pc_stall),
        .pc_flush     (pc_flush),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .mc_busy      (mc_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Drive one vector's inputs on a falling edge so they settle before the next rise.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        pc_cur       = v.pc;
        id_rs1       = v.rs1;
        id_rs2       = v.rs2;
        id_use_rs1   = v.use1;
        id_use_rs2   = v.use2;
        ex_rd        = v.rd;
        ex_mem_read  = v.mem_rd;
        ex_mc_start  = v.mc_start;
        br_taken_ex  = v.br;
        br_target_ex = v.tgt;
        trap_req_mem = v.trap;
    endtask

    // Compare outputs against expectations; mask selects which strobes matter.
    task automatic checkOutput(input string name, input logic chk_pc,
                               input logic [63:0] exp_pc,
                               input logic [7:0] exp_str, input logic [7:0] mask);
        logic [7:0] got;
        #2;
        got = {pc_stall, pc_flush, if_id_stall, if_id_flush,
               id_ex_stall, id_ex_flush, ex_mem_flush, mc_busy};
        total++;
        if ((chk_pc && (pc_next !== exp_pc)) || ((got & mask) !== (exp_str & mask))) begin
            bad++;
            $display("[TB] FAIL %s: pc_next=%h want %h strobes=%b want %b (mask %b)",
                     name, pc_next, exp_pc, got, exp_str, mask);
        end
    endtask

    // Return all inputs to a quiet sequential-fetch pattern at the given PC.
    task automatic idleInputs(input logic [63:0] pc);
        vec_t v;
        v = '{"idle", pc, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 8'd0};
        applyStimulus(v);
    endtask

    initial begin
        vecs[0]  = '{"seq",          64'h1000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 64'h1004, S_NONE};
        vecs[1]  = '{"lu_rs2",       64'h1000, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 64'h1004, S_LU};
        vecs[2]  = '{"lu_rd0",       64'h1000, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 64'h1004, S_NONE};
        vecs[3]  = '{"lu_rs1_unused",64'h1000, 5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 64'h1004, S_NONE};
        vecs[4]  = '{"lu_rs1",       64'h1040, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 64'h0,    1'b0, 64'h1044, S_LU};
        vecs[5]  = '{"no_load",      64'h1040, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 64'h0,    1'b0, 64'h1044, S_NONE};
        vecs[6]  = '{"branch",       64'h1000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 64'h2000, 1'b0, 64'h2000, S_BR};
        vecs[7]  = '{"branch_over_lu",64'h1000,5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 64'h3000, 1'b0, 64'h3000, S_BR};
        vecs[8]  = '{"trap_over_br", 64'h1000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 64'h2000, 1'b1, 64'h100,  S_TRAP};
        vecs[9]  = '{"pc_wrap",      64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, S_NONE};
        vecs[10] = '{"trap_mc",      64'h1000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 64'h0,    1'b1, 64'h100,  S_TRAP};
        vecs[11] = '{"branch_mc",    64'h1000, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 64'h2400, 1'b0, 64'h2400, S_BR};

        // Reset: strobes silent and pc_next still increments, even with a trap pending.
        rst = 1'b1;
        idleInputs(64'h40);
        trap_req_mem = 1'b1;
        checkOutput("reset", 1'b1, 64'h44, S_NONE, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        trap_req_mem = 1'b0;

        // Table vectors: none of them leave RUN.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, 1'b1, vecs[i].exp_pc, vecs[i].exp_str, 8'hFF);
        end
        idleInputs(64'h1000);
        checkOutput("still_run", 1'b1, 64'h1004, S_NONE, 8'hFF);

        // Multi-cycle op with a coincident load-use: start cycle has no stall,
        // then exactly three busy cycles ignoring a taken branch, then RUN.
        idleInputs(64'h1000);
        ex_mc_start = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        checkOutput("mc_start", 1'b1, 64'h1004, S_NONE, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            idleInputs(64'h1004);
            br_taken_ex = 1'b1; br_target_ex = 64'h2000;
            checkOutput($sformatf("mc_busy%0d", c), 1'b0, 64'h0, S_BUSY, 8'hFF);
        end
        idleInputs(64'h1004);
        br_taken_ex = 1'b1; br_target_ex = 64'h2000;
        checkOutput("mc_done_branch", 1'b1, 64'h2000, S_BR, 8'hFF);

        // Trap on the second busy cycle aborts the op.
        idleInputs(64'h2000);
        ex_mc_start = 1'b1;
        checkOutput("mc2_start", 1'b1, 64'h2004, S_NONE, 8'hFF);
        idleInputs(64'h2004);
        checkOutput("mc2_busy0", 1'b0, 64'h0, S_BUSY, 8'hFF);
        idleInputs(64'h2004);
        trap_req_mem = 1'b1;
        checkOutput("mc2_trap", 1'b1, 64'h100, S_TRAP, 8'hFE);
        idleInputs(64'h100);
        checkOutput("after_trap", 1'b1, 64'h104, S_NONE, 8'hFF);

        // Reset during MC_WAIT, then a fresh op counts the full latency again.
        idleInputs(64'h3000);
        ex_mc_start = 1'b1;
        checkOutput("mc3_start", 1'b1, 64'h3004, S_NONE, 8'hFF);
        idleInputs(64'h3004);
        checkOutput("mc3_busy0", 1'b0, 64'h0, S_BUSY, 8'hFF);
        idleInputs(64'h3004);
        rst = 1'b1;
        checkOutput("mc3_in_reset", 1'b1, 64'h3008, S_NONE, 8'hFF);
        idleInputs(64'h0);
        rst = 1'b0;
        checkOutput("after_reset", 1'b1, 64'h4, S_NONE, 8'hFF);
        idleInputs(64'h4);
        ex_mc_start = 1'b1;
        checkOutput("mc4_start", 1'b1, 64'h8, S_NONE, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            idleInputs(64'h8);
            checkOutput($sformatf("mc4_busy%0d", c), 1'b0, 64'h0, S_BUSY, 8'hFF);
        end
        idleInputs(64'h8);
        checkOutput("mc4_done", 1'b1, 64'hC, S_NONE, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
